// File: rtl/imc_instr_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : imc_instr_issue_if
// Purpose  : Bundles the host push handshake and the decoder-facing issue
//            signals of imc_instr_issue into one interface.
// Signals  : flush, in_valid, in_instr  (host -> queue)
//            in_ready                   (queue -> host)
//            instruction, instr_valid   (queue -> decoder)
//            busy, count                (status)
//            in_parity / parity_err     (only with IMC_ISSUE_PARITY_EN)
// Modports : master = host/driver side, slave = imc_instr_issue side
// Macro    : IMC_ISSUE_PARITY_EN adds the parity signals
// Revision : 1.0  initial release
// ============================================================================
interface imc_instr_issue_if #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int DEPTH            = 4
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                        flush;
    logic                        in_valid;
    logic [INSTRUCTION_SIZE-1:0] in_instr;
    logic                        in_ready;
    logic [INSTRUCTION_SIZE-1:0] instruction;
    logic                        instr_valid;
    logic                        busy;
    logic [c_cnt_w-1:0]          count;
`ifdef IMC_ISSUE_PARITY_EN
    logic                        in_parity;
    logic                        parity_err;

    modport master (
        output flush, in_valid, in_instr, in_parity,
        input  in_ready, instruction, instr_valid, busy, count, parity_err
    );

    modport slave (
        input  flush, in_valid, in_instr, in_parity,
        output in_ready, instruction, instr_valid, busy, count, parity_err
    );
`else
    modport master (
        output flush, in_valid, in_instr,
        input  in_ready, instruction, instr_valid, busy, count
    );

    modport slave (
        input  flush, in_valid, in_instr,
        output in_ready, instruction, instr_valid, busy, count
    );
`endif

endinterface : imc_instr_issue_if
`default_nettype wire

// File: rtl/imc_instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : imc_instr_issue
// Purpose  : Instruction queue and issue pacer sitting directly upstream of
//            imc_decoder. Host words enter a DEPTH-entry FIFO over a
//            valid/ready handshake and are presented one at a time on
//            bus.instruction, each held stable for an opcode-dependent number
//            of cycles (majority ops 100/101 need multi-cycle array access).
// Ports    : clk  - clock, rising edge
//            rst  - synchronous reset, active low
//            bus  - imc_instr_issue_if.slave (flush, push handshake, issued
//                   word, instr_valid, busy, count)
// Macro    : IMC_ISSUE_PARITY_EN - even-parity check on pushed words; a bad
//            word is consumed but dropped and sets sticky bus.parity_err
// Revision : 1.0  initial release
// ============================================================================
module imc_instr_issue #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int DEPTH            = 4,
    parameter int HOLD_MIG         = 3,
    parameter int HOLD_OTHER       = 1
) (
    input  logic             clk,
    input  logic             rst,
    imc_instr_issue_if.slave bus
);

    localparam int                 c_addr_w         = $clog2(DEPTH);
    localparam int                 c_cnt_w          = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full           = c_cnt_w'(DEPTH);
    localparam logic [3:0]         c_hold_mig_m1    = 4'(HOLD_MIG - 1);
    localparam logic [3:0]         c_hold_other_m1  = 4'(HOLD_OTHER - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                      state_q,       state_d;
    logic [INSTRUCTION_SIZE-1:0] mem_q [DEPTH];
    logic [INSTRUCTION_SIZE-1:0] mem_d [DEPTH];
    logic [c_addr_w-1:0]         wr_ptr_q,      wr_ptr_d;
    logic [c_addr_w-1:0]         rd_ptr_q,      rd_ptr_d;
    logic [c_cnt_w-1:0]          count_q,       count_d;
    logic [3:0]                  hcnt_q,        hcnt_d;
    logic [INSTRUCTION_SIZE-1:0] instruction_q, instruction_d;
    logic                        instr_valid_q, instr_valid_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                        w_in_ready;
    logic                        w_push;
    logic                        w_wr_en;
    logic                        w_pop;
    logic [INSTRUCTION_SIZE-1:0] w_head;
    logic [2:0]                  w_head_op;
    logic [3:0]                  w_head_hold_m1;
    logic                        w_not_empty;

    // Full is judged on the registered count, so a pop on the same edge
    // only frees the slot for the following cycle.
    assign w_in_ready  = !bus.flush && (count_q != c_full);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_not_empty = (count_q != '0);

    assign w_head    = mem_q[rd_ptr_q];
    assign w_head_op = w_head[INSTRUCTION_SIZE-1 -: 3];

    // Counter is loaded with H-1 so a word is held exactly H cycles.
    assign w_head_hold_m1 = ((w_head_op == 3'b100) || (w_head_op == 3'b101))
                            ? c_hold_mig_m1 : c_hold_other_m1;

`ifdef IMC_ISSUE_PARITY_EN
    logic w_parity_ok;
    logic parity_err_q, parity_err_d;

    // Even parity: XOR of the word must equal the supplied parity bit.
    assign w_parity_ok = ((^bus.in_instr) == bus.in_parity);
    // Bad words complete the handshake but never reach the FIFO.
    assign w_wr_en     = w_push && w_parity_ok;

    always_comb begin
        parity_err_d = parity_err_q;
        if (bus.flush) begin
            parity_err_d = 1'b0;
        end else if (w_push && !w_parity_ok) begin
            parity_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign w_wr_en = w_push;
`endif

    // ------------------------------------------------------------------
    // Issue FSM: next state, hold counter and issued word
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        w_pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop         = 1'b1;
                    instruction_d = w_head;
                    instr_valid_d = 1'b1;
                    hcnt_d        = w_head_hold_m1;
                    state_d       = S_ISSUE;
                end else begin
                    instr_valid_d = 1'b0;
                end
            end
            S_ISSUE: begin
                if (hcnt_q != 4'd0) begin
                    hcnt_d = hcnt_q - 4'd1;
                end else if (w_not_empty) begin
                    // Back-to-back issue: next word replaces the current
                    // one with no idle cycle in between.
                    w_pop         = 1'b1;
                    instruction_d = w_head;
                    instr_valid_d = 1'b1;
                    hcnt_d        = w_head_hold_m1;
                end else begin
                    instr_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
                hcnt_d        = 4'd0;
            end
        endcase

        // Flush truncates any word in flight; the last issued word stays
        // on the bus (qualified low) so the decoder input does not toggle.
        if (bus.flush) begin
            state_d       = S_IDLE;
            instr_valid_d = 1'b0;
            hcnt_d        = 4'd0;
            w_pop         = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage, pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_wr_en) begin
                mem_d[wr_ptr_q] = bus.in_instr;
                // DEPTH is a power of two, so pointers wrap naturally.
                wr_ptr_d        = wr_ptr_q + c_addr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_addr_w'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   count_d = count_q + c_cnt_w'(1);
                2'b01:   count_d = count_q - c_cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers (reset has priority over flush and push)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            hcnt_q        <= 4'd0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            hcnt_q        <= hcnt_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = w_in_ready;
    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.busy        = instr_valid_q || w_not_empty;
    assign bus.count       = count_q;

endmodule : imc_instr_issue
`default_nettype wire

// File: tb/tb_imc_instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_imc_instr_issue
// Purpose  : Scoreboard bench for imc_instr_issue. The driver queues the
//            expected word and hold length for every accepted push; an
//            independent monitor pops and compares whenever the DUT issues.
// Macro    : IMC_ISSUE_PARITY_EN enables the parity scenario
// Revision : 1.0  initial release
// ============================================================================
module tb_imc_instr_issue;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imc_instr_issue_if #(.INSTRUCTION_SIZE(32), .DEPTH(4)) bus ();

    imc_instr_issue #(
        .INSTRUCTION_SIZE (32),
        .DEPTH            (4),
        .HOLD_MIG         (3),
        .HOLD_OTHER       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] w;
        int          hold;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Monitor state
    int          rem        = 0;
    logic [31:0] cur        = '0;
    bit          prev_valid = 1'b0;
    bit          flush_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int exp_hold(input logic [31:0] w);
        logic [2:0] op;
        op = w[31:29];
        return ((op == 3'b100) || (op == 3'b101)) ? 3 : 1;
    endfunction

    // Drive one word; the word is scored only once the handshake is certain.
    task automatic drive(input logic [31:0] w, input bit expect_issue);
        int   n;
        exp_t e;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        while (!bus.in_ready && n <= 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=in_ready_low required=accept word=%h", w);
            bus.in_valid = 1'b0;
        end else begin
            if (expect_issue) begin
                e.w    = w;
                e.hold = exp_hold(w);
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic push(input logic [31:0] w);
`ifdef IMC_ISSUE_PARITY_EN
        bus.in_parity = ^w;
`endif
        drive(w, 1'b1);
    endtask

`ifdef IMC_ISSUE_PARITY_EN
    task automatic push_par(input logic [31:0] w, input logic p);
        bus.in_parity = p;
        drive(w, (p == (^w)));
    endtask
`endif

    // ------------------------------------------------------------------
    // Monitor: checks order, stability and exact hold length of issues
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (flush_seen) begin
                chk("mon_flush_valid", {31'b0, bus.instr_valid}, 32'd0);
                flush_seen = 1'b0;
                rem        = 0;
            end else if (bus.instr_valid) begin
                if (rem > 0) begin
                    chk("mon_hold_stable", bus.instruction, cur);
                    rem--;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected_issue actual=%h required=no_issue t=%0t",
                             bus.instruction, $time);
                end else begin
                    e   = exp_q.pop_front();
                    chk("mon_issue_order", bus.instruction, e.w);
                    cur = e.w;
                    rem = e.hold - 1;
                end
            end else if (prev_valid) begin
                chk("mon_hold_length", 32'(rem), 32'd0);
            end
            prev_valid = bus.instr_valid;
            if (bus.flush) begin
                exp_q.delete();
                rem        = 0;
                flush_seen = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hDEADBEEF;
`ifdef IMC_ISSUE_PARITY_EN
        bus.in_parity = 1'b0;
`endif
        // 1: reset with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instruction", bus.instruction, 32'd0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        mon_en       = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // 2: majority word held 3 cycles
        push(32'h83000000);
        @(negedge clk);
        chk("mig_count_n", 32'(bus.count), 32'd1);
        chk("mig_valid_n", {31'b0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        chk("mig_valid_n1", {31'b0, bus.instr_valid}, 32'd1);
        chk("mig_word_n1", bus.instruction, 32'h83000000);
        chk("mig_count_n1", 32'(bus.count), 32'd0);
        @(negedge clk);
        chk("mig_valid_n2", {31'b0, bus.instr_valid}, 32'd1);
        @(negedge clk);
        chk("mig_valid_n3", {31'b0, bus.instr_valid}, 32'd1);
        @(negedge clk);
        chk("mig_valid_n4", {31'b0, bus.instr_valid}, 32'd0);
        chk("mig_busy_n4", {31'b0, bus.busy}, 32'd0);

        // 3: two single-cycle words back to back
        push(32'h1A800000);
        push(32'h38000000);
        @(negedge clk);
        chk("b2b_first", bus.instruction, 32'h1A800000);
        chk("b2b_count", 32'(bus.count), 32'd1);
        @(negedge clk);
        chk("b2b_second", bus.instruction, 32'h38000000);
        chk("b2b_second_valid", {31'b0, bus.instr_valid}, 32'd1);
        @(negedge clk);
        chk("b2b_end_valid", {31'b0, bus.instr_valid}, 32'd0);

        // 4: fill while the first word is held, then overflow attempt
        push(32'hA0000011);
        push(32'h80000022);
        push(32'h80000033);
        push(32'h80000044);
        push(32'h80000055);
        push(32'hA0000066);
        @(negedge clk);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_in_ready", {31'b0, bus.in_ready}, 32'd0);
        push(32'h00000077);
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fill_drained_busy", {31'b0, bus.busy}, 32'd0);
        chk("fill_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 5: flush in the second cycle of a majority hold with count=2
        push(32'h8A000000);
        push(32'h40000001);
        push(32'h60000002);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_count", 32'(bus.count), 32'd2);
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("flush_pre_valid", {31'b0, bus.instr_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_word_kept", bus.instruction, 32'h8A000000);
        push(32'h20000001);
        @(negedge clk);
        chk("post_flush_wait", {31'b0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        chk("post_flush_issue", bus.instruction, 32'h20000001);
        chk("post_flush_valid", {31'b0, bus.instr_valid}, 32'd1);
        repeat (2) @(negedge clk);

`ifdef IMC_ISSUE_PARITY_EN
        // 6: wrong parity word consumed but dropped
        push_par(32'hF8000000, 1'b0);
        @(negedge clk);
        chk("par_count", 32'(bus.count), 32'd0);
        chk("par_err", {31'b0, bus.parity_err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("par_not_issued", {31'b0, bus.instr_valid}, 32'd0);
        chk("par_err_sticky", {31'b0, bus.parity_err}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("par_err_cleared", {31'b0, bus.parity_err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imc_instr_issue
`default_nettype wire
